// File: rtl/led_pwm_multi.sv
// Multi-channel LED PWM generator: one shared period counter drives CHANNELS
// outputs, each with solid or breathing duty applied only at period boundaries.
module led_pwm_multi #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int DIV      = 1,
   parameter  int STEP     = 4,
   localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [CHW-1:0]      wr_ch,
   input  logic [WIDTH-1:0]    wr_duty,
   input  logic                wr_mode,
   input  logic [CHW-1:0]      rd_ch,
   output logic [WIDTH-1:0]    rd_duty,
   output logic [CHANNELS-1:0] led_signal,
   output logic                period_start
);
   localparam int               DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
   localparam logic [WIDTH-1:0] MAX      = '1;
   localparam logic [WIDTH:0]   MAX_X    = {1'b0, MAX};
   localparam logic [WIDTH:0]   STEP_X   = (WIDTH + 1)'(STEP);
   localparam logic [CHW:0]     CH_LIM   = (CHW + 1)'(CHANNELS);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

   logic [DW-1:0]       div_cnt;
   logic [WIDTH-1:0]    cnt;
   logic                tick;
   logic                boundary;
   logic                wr_ok;

   logic [WIDTH-1:0]    pend_duty [CHANNELS];
   logic [WIDTH-1:0]    act_duty  [CHANNELS];
   logic [WIDTH-1:0]    nxt_duty  [CHANNELS];
   dir_e                dir       [CHANNELS];
   dir_e                nxt_dir   [CHANNELS];
   logic [CHANNELS-1:0] pend_mode;
   logic [CHANNELS-1:0] pend_new;
   logic [CHANNELS-1:0] act_mode;
   logic [CHANNELS-1:0] nxt_mode;
   logic [CHANNELS-1:0] wr_hit;

   logic [WIDTH-1:0]    eff_duty;
   logic                eff_new;
   logic [WIDTH:0]      sum;
   logic [WIDTH:0]      diff;

   assign tick     = (div_cnt == DIV_LAST);
   assign boundary = tick && (cnt == MAX);
   assign wr_ok    = wr_en && ({1'b0, wr_ch} < CH_LIM);
   assign rd_duty  = ({1'b0, rd_ch} < CH_LIM) ? act_duty[rd_ch] : '0;

   // Next-period duty per channel; a write landing on the boundary cycle is
   // folded in here so it takes effect at that same boundary.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      wr_hit   = '0;
      nxt_mode = '0;
      eff_duty = '0;
      eff_new  = 1'b0;
      sum      = '0;
      diff     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         nxt_duty[i] = act_duty[i];
         nxt_dir[i]  = dir[i];
         wr_hit[i]   = wr_ok && (wr_ch == CHW'(i));
         eff_duty    = wr_hit[i] ? wr_duty : pend_duty[i];
         nxt_mode[i] = wr_hit[i] ? wr_mode : pend_mode[i];
         eff_new     = wr_hit[i] || pend_new[i];
         sum         = {1'b0, act_duty[i]} + STEP_X;
         diff        = {1'b0, act_duty[i]} - STEP_X;
         if (eff_new || (nxt_mode[i] && !act_mode[i])) begin
            nxt_duty[i] = eff_duty;
            nxt_dir[i]  = DIR_UP;
         end else if (act_mode[i]) begin
            if (dir[i] == DIR_UP) begin
               if (sum >= MAX_X) begin
                  nxt_duty[i] = MAX;
                  nxt_dir[i]  = DIR_DOWN;
               end else begin
                  nxt_duty[i] = sum[WIDTH-1:0];
               end
            end else begin
               // diff[WIDTH] set means the subtraction went below zero
               if (diff[WIDTH] || (diff == '0)) begin
                  nxt_duty[i] = '0;
                  nxt_dir[i]  = DIR_UP;
               end else begin
                  nxt_duty[i] = diff[WIDTH-1:0];
               end
            end
         end else begin
            nxt_duty[i] = eff_duty;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt      <= '0;
         cnt          <= '0;
         led_signal   <= '0;
         period_start <= 1'b0;
         pend_mode    <= '0;
         pend_new     <= '0;
         act_mode     <= '0;
         // NOTE: the per-channel arrays are reset explicitly because duties must come up at zero.
         for (int i = 0; i < CHANNELS; i++) begin
            pend_duty[i] <= '0;
            act_duty[i]  <= '0;
            dir[i]       <= DIR_UP;
         end
      end else begin
         div_cnt      <= tick ? '0 : div_cnt + 1'b1;
         period_start <= boundary;
         if (tick) begin
            cnt <= cnt + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
               led_signal[i] <= (act_duty[i] == MAX) || (cnt < act_duty[i]);
            end
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit[i]) begin
               pend_duty[i] <= wr_duty;
               pend_mode[i] <= wr_mode;
            end
            if (boundary) begin
               act_duty[i] <= nxt_duty[i];
               dir[i]      <= nxt_dir[i];
               act_mode[i] <= nxt_mode[i];
               pend_new[i] <= 1'b0;
            end else if (wr_hit[i]) begin
               pend_new[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_multi.sv
// Directed bench for led_pwm_multi: a DIV=1, 4-channel instance and a DIV=3,
// 5-channel instance (the latter also exercises out-of-range channel numbers).
module tb_led_pwm_multi;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WIDTH=8, CHANNELS=4, DIV=1, STEP=4
   logic       rst_a, wr_en_a, wr_mode_a, ps_a;
   logic [1:0] wr_ch_a, rd_ch_a;
   logic [7:0] wr_duty_a, rd_duty_a;
   logic [3:0] led_a;

   // Instance B: WIDTH=8, CHANNELS=5, DIV=3, STEP=4
   logic       rst_b, wr_en_b, wr_mode_b, ps_b;
   logic [2:0] wr_ch_b, rd_ch_b;
   logic [7:0] wr_duty_b, rd_duty_b;
   logic [4:0] led_b;

   led_pwm_multi #(.WIDTH(8), .CHANNELS(4), .DIV(1), .STEP(4)) dut_a (
      .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_duty(wr_duty_a),
      .wr_mode(wr_mode_a), .rd_ch(rd_ch_a), .rd_duty(rd_duty_a),
      .led_signal(led_a), .period_start(ps_a));

   led_pwm_multi #(.WIDTH(8), .CHANNELS(5), .DIV(3), .STEP(4)) dut_b (
      .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_ch(wr_ch_b), .wr_duty(wr_duty_b),
      .wr_mode(wr_mode_b), .rd_ch(rd_ch_b), .rd_duty(rd_duty_b),
      .led_signal(led_b), .period_start(ps_b));

   typedef struct {
      int ch;
      int duty;
      bit mode;
      int exp_high;
      int exp_rise;
   } vec_t;

   typedef struct {
      int ch;
      int exp_duty;
   } rd_vec_t;

   vec_t    solid_tab  [4];
   int      breath_tab [5];
   int      tail_tab   [4];
   rd_vec_t rd_tab     [7];

   int checks   = 0;
   int failures = 0;
   int hi_cnt   [5];
   int rise_cnt [5];
   int ps_seen;
   int ps_last;
   int cyc;
   int hi;
   int n;
   bit quiet;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic sample(input bit sel, output logic [4:0] led, output logic ps);
      if (sel) begin
         led = led_b;
         ps  = ps_b;
      end else begin
         led = {1'b0, led_a};
         ps  = ps_a;
      end
   endtask

   // Step negedges until period_start is seen (returns at once if already high).
   task automatic wait_ps(input bit sel, input int budget, input string name);
      logic [4:0] l;
      logic       p;
      int         k;
      k = 0;
      sample(sel, l, p);
      while (!p && k < budget) begin
         @(negedge clk);
         k++;
         sample(sel, l, p);
      end
      check(name, p, 1);
   endtask

   // Sample len cycles following the current one; count highs, rising edges, pulses.
   task automatic measure(input bit sel, input int len);
      logic [4:0] l;
      logic [4:0] prev;
      logic       p;
      sample(sel, prev, p);
      for (int i = 0; i < 5; i++) begin
         hi_cnt[i]   = 0;
         rise_cnt[i] = 0;
      end
      ps_seen = 0;
      ps_last = 0;
      for (int j = 1; j <= len; j++) begin
         @(negedge clk);
         sample(sel, l, p);
         for (int i = 0; i < 5; i++) begin
            if (l[i]) hi_cnt[i]++;
            if (l[i] && !prev[i]) rise_cnt[i]++;
         end
         if (p) begin
            ps_seen++;
            ps_last = j;
         end
         prev = l;
      end
   endtask

   task automatic write_a(input int ch, input int duty, input bit mode);
      wr_en_a   = 1'b1;
      wr_ch_a   = ch[1:0];
      wr_duty_a = duty[7:0];
      wr_mode_a = mode;
      @(negedge clk);
      wr_en_a   = 1'b0;
   endtask

   task automatic write_b(input int ch, input int duty, input bit mode);
      wr_en_b   = 1'b1;
      wr_ch_b   = ch[2:0];
      wr_duty_b = duty[7:0];
      wr_mode_b = mode;
      @(negedge clk);
      wr_en_b   = 1'b0;
   endtask

   function automatic int exp_high(input int duty);
      return (duty == 255) ? 256 : duty;
   endfunction

   initial begin
      rst_a = 1'b0; wr_en_a = 1'b0; wr_ch_a = '0; wr_duty_a = '0; wr_mode_a = 1'b0; rd_ch_a = '0;
      rst_b = 1'b0; wr_en_b = 1'b0; wr_ch_b = '0; wr_duty_b = '0; wr_mode_b = 1'b0; rd_ch_b = '0;

      solid_tab[0] = '{0,  64, 1'b0,  64, 1};
      solid_tab[1] = '{1,   0, 1'b0,   0, 0};
      solid_tab[2] = '{2, 255, 1'b0, 256, 1};
      solid_tab[3] = '{3, 128, 1'b0, 128, 1};
      breath_tab   = '{248, 252, 255, 251, 247};
      tail_tab     = '{3, 0, 4, 8};
      rd_tab[0] = '{0, 16};
      rd_tab[1] = '{1, 0};
      rd_tab[2] = '{2, 0};
      rd_tab[3] = '{3, 0};
      rd_tab[4] = '{4, 0};
      rd_tab[5] = '{5, 0};
      rd_tab[6] = '{7, 0};

      // Reset held for three edges; cycle 1 is the one after the last reset edge.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_led", led_a, 0);
      check("reset_ps", ps_a, 0);
      rd_ch_a = 2'd3;
      #1;
      check("reset_rd", rd_duty_a, 0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      cyc   = 1;
      quiet = 1'b1;
      while (!ps_a && cyc < 400) begin
         if (led_a != 4'b0000) quiet = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check("reset_quiet", quiet, 1);
      check("first_ps_cycle", cyc, 257);

      // Solid duties on all four channels
      for (int i = 0; i < 4; i++) write_a(solid_tab[i].ch, solid_tab[i].duty, solid_tab[i].mode);
      wait_ps(0, 600, "solid_wait");
      measure(0, 256);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("solid_high_ch%0d", i), hi_cnt[solid_tab[i].ch], solid_tab[i].exp_high);
         check($sformatf("solid_rise_ch%0d", i), rise_cnt[solid_tab[i].ch], solid_tab[i].exp_rise);
      end
      rd_ch_a = 2'd3;
      #1;
      check("solid_rd_ch3", rd_duty_a, 128);

      // Mid-period rewrite of ch0 at cnt=100
      hi      = 0;
      rd_ch_a = 2'd0;
      for (int j = 1; j <= 256; j++) begin
         @(negedge clk);
         if (j == 100) begin
            wr_en_a = 1'b1; wr_ch_a = 2'd0; wr_duty_a = 8'd200; wr_mode_a = 1'b0;
         end
         if (j == 101) wr_en_a = 1'b0;
         if (led_a[0]) hi++;
         if (j == 150) begin
            #1;
            check("mid_rd_old", rd_duty_a, 64);
         end
      end
      check("mid_old_high", hi, 64);
      check("mid_ps_end", ps_a, 1);
      measure(0, 256);
      check("mid_new_high", hi_cnt[0], 200);
      check("mid_new_rise", rise_cnt[0], 1);

      // Write on the boundary cycle (cnt=255) is applied at that boundary
      repeat (255) @(negedge clk);
      write_a(2, 10, 1'b0);
      check("coll_ps", ps_a, 1);
      measure(0, 256);
      check("coll_high_ch2", hi_cnt[2], 10);
      check("coll_high_ch0", hi_cnt[0], 200);
      rd_ch_a = 2'd2;
      #1;
      check("coll_rd_ch2", rd_duty_a, 10);

      // Breathing on ch1 from 248
      write_a(1, 248, 1'b1);
      wait_ps(0, 600, "breath_wait");
      for (int k = 0; k < 5; k++) begin
         rd_ch_a = 2'd1;
         #1;
         check($sformatf("breath_duty_%0d", k), rd_duty_a, breath_tab[k]);
         measure(0, 256);
         check($sformatf("breath_high_%0d", k), hi_cnt[1], exp_high(breath_tab[k]));
      end
      n = 0;
      #1;
      while (rd_duty_a != 8'd3 && n < 80) begin
         @(negedge clk);
         wait_ps(0, 300, "breath_walk");
         #1;
         n++;
      end
      check("breath_reach3", rd_duty_a, 3);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("breath_tail_duty_%0d", k), rd_duty_a, tail_tab[k]);
         measure(0, 256);
         check($sformatf("breath_tail_high_%0d", k), hi_cnt[1], tail_tab[k]);
         #1;
      end

      // Divider instance: one valid write, two writes to nonexistent channels
      write_b(0, 16, 1'b0);
      write_b(5, 99, 1'b1);
      write_b(7, 50, 1'b0);
      wait_ps(1, 2000, "div_wait");
      measure(1, 768);
      check("div_high_ch0", hi_cnt[0], 48);
      check("div_high_others", hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + hi_cnt[4], 0);
      check("div_ps_count", ps_seen, 1);
      check("div_ps_pos", ps_last, 768);
      for (int i = 0; i < 7; i++) begin
         rd_ch_b = rd_tab[i].ch[2:0];
         #1;
         check($sformatf("div_rd_ch%0d", rd_tab[i].ch), rd_duty_b, rd_tab[i].exp_duty);
      end

      // Reset mid-period with a write attempted during reset
      rd_ch_b = 3'd0;
      repeat (9) @(negedge clk);
      check("div_pre_reset_high", led_b[0], 1);
      rst_b = 1'b0;
      wr_en_b = 1'b1; wr_ch_b = 3'd0; wr_duty_b = 8'd200; wr_mode_b = 1'b0;
      @(negedge clk);
      check("div_reset_led", led_b, 0);
      check("div_reset_ps", ps_b, 0);
      check("div_reset_rd", rd_duty_b, 0);
      rst_b   = 1'b1;
      wr_en_b = 1'b0;
      cyc     = 1;
      quiet   = 1'b1;
      while (!ps_b && cyc < 1000) begin
         if (led_b != 5'b00000) quiet = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check("div_after_reset_quiet", quiet, 1);
      check("div_first_ps_cycle", cyc, 769);
      check("div_reset_write_ignored", rd_duty_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
